meter_pulse_counter: RTL and testbench
======================================

METER_PULSE_COUNTER -- requirements
Module: meter_pulse_counter

Interface
REQ-001 Parameter PULSES_PER_UNIT, default 10: debounced meter pulses per billed unit (range 2..255).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable clk samples needed to accept a pulse-line level change (range 2..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pulse_in  input  1  raw meter impulse line, asynchronous to clk, may bounce.
REQ-006 clear_req  input  1  one-cycle request to zero the running count (new billing cycle).
REQ-007 snap_req  input  1  request to publish the current unit count.
REQ-008 units_today  output  13  published cumulative unit count; feeds the billing machine unitsToday input.
REQ-009 units_valid  output  1  units_today holds a published snapshot.
REQ-010 units_ready  input  1  consumer accepts the snapshot.
REQ-011 overflow  output  1  sticky flag: unit count saturated.

Function
REQ-012 pulse_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounced level SHALL change only after the synchronized sample differs from it on DEBOUNCE_CYCLES consecutive cycles; any agreeing sample resets the difference counter.
REQ-014 A 0->1 transition of the debounced level SHALL count as exactly one pulse; 1->0 transitions count nothing.
REQ-015 Prescaler SHALL count accepted pulses 0..PULSES_PER_UNIT-1; on the pulse that would reach PULSES_PER_UNIT it wraps to 0 and the 13-bit unit count increments by 1.
REQ-016 Unit count SHALL saturate at 8191; an increment at 8191 leaves the count at 8191 and sets overflow.
REQ-017 clear_req SHALL zero unit count, prescaler and overflow on the next edge; clear wins over a coincident increment.
REQ-018 Publish FSM states: IDLE, HOLD.
REQ-019 IDLE with snap_req=1 at an edge: units_today loads the unit count present before that edge, units_valid=1, state -> HOLD (1-cycle latency).
REQ-020 HOLD: units_today SHALL stay constant; snap_req ignored; clear_req and new pulses affect only the running count.
REQ-021 HOLD with units_ready=1 at an edge: units_valid=0, state -> IDLE; a snap_req on that same edge is ignored (new request needs IDLE).
REQ-022 units_ready while IDLE SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force: synchronizer flops, debounced level, difference counter, prescaler and unit count to 0; state IDLE; units_today=0; units_valid=0; overflow=0.
REQ-024 Reset asserted mid-debounce or during HOLD SHALL abandon the pending pulse/snapshot; no pulse is counted from a level already high at reset release until it falls and rises again.

Structure
REQ-025 Shared package ebm_pkg SHALL hold the publish-state enum (IDLE, HOLD), UNITS_W=13, UNITS_MAX=8191 and the parameter defaults.
REQ-026 Synchronizer plus debouncer plus rising-edge detect SHALL be one sub-module, pulse_debouncer, outputting a one-cycle pulse strobe.

Verification
REQ-027 Clean pulses, PULSES_PER_UNIT=10: 25 clean pulses (each high 8 cycles, low 8), then snap_req -> units_today=2, units_valid=1 next cycle; prescaler holds 5.
REQ-028 Bounce: each rising edge preceded by 3 one-cycle glitches, DEBOUNCE_CYCLES=4 -> glitches rejected, 10 bouncy pulses -> units_today=1.
REQ-029 Handshake: snap_req with units_ready=0 for 5 cycles while 10 more pulses arrive -> units_today unchanged and valid held; units_ready=1 -> valid low next cycle; new snap_req -> incremented value.
REQ-030 Saturation: clear then count preset so unit count=8190, feed 20 pulses -> count 8191, overflow=1; clear_req -> count 0, overflow 0.
REQ-031 Simultaneity: clear_req on the same edge as the 10th pulse of a unit -> count 0, prescaler 0.
REQ-032 Reset: assert rst_n low during HOLD with pulse_in held high -> units_valid=0, units_today=0 immediately; after release no pulse counted until pulse_in falls and rises.

Source files
------------

// File: rtl/ebm_pkg.sv
// Shared types and constants for the energy billing meter pulse counter.
package ebm_pkg;

    // Snapshot publish state: StIdle waits for a request, StHold presents it.
    typedef enum logic [0:0] {
        StIdle,
        StHold
    } pub_state_e;

    localparam int unsigned UNITS_W             = 13;
    localparam int unsigned UNITS_MAX           = 8191;
    localparam int unsigned PULSES_PER_UNIT_DEF = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/meter_pulse_counter_if.sv
// Snapshot request/publish handshake between the counter and the billing machine.
interface meter_pulse_counter_if;
    import ebm_pkg::*;

    logic               snap_req;
    logic [UNITS_W-1:0] units_today;
    logic               units_valid;
    logic               units_ready;

    // master: the counter publishing snapshots; slave: the consumer.
    modport master (
        input  snap_req,
        input  units_ready,
        output units_today,
        output units_valid
    );

    modport slave (
        output snap_req,
        output units_ready,
        input  units_today,
        input  units_valid
    );

endinterface

// File: rtl/pulse_debouncer.sv
// Synchronizes and debounces the raw meter line and emits a one-cycle strobe
// per accepted rising edge.
module pulse_debouncer
    import ebm_pkg::*;
#(
    parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic pulse_stb_o
);

    localparam int unsigned   CntW    = 4;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [1:0]      sync_q;
    logic [1:0]      vld_q;
    logic            synced;
    logic            level_q, level_d;
    logic [CntW-1:0] diff_q, diff_d;
    logic [CntW-1:0] arm_cnt_q, arm_cnt_d;
    logic            armed_q, armed_d;
    logic            stb_q, stb_d;

    assign synced      = sync_q[1];
    assign pulse_stb_o = stb_q;

    // Two-flop synchronizer; vld_q marks when sync_q[1] holds a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pulse_in};
            vld_q  <= {vld_q[0], 1'b1};
        end
    end

    // Debounce, arm and rising-edge detect next-state logic.
    always_comb begin
        level_d   = level_q;
        diff_d    = '0;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        stb_d     = 1'b0;

        if (synced != level_q) begin
            if (diff_q == CntLast) begin
                level_d = synced;
                stb_d   = synced & armed_q;
            end else begin
                diff_d = diff_q + 1'b1;
            end
        end

        // A line already high at reset release must show a debounced low
        // before any rising edge may count.
        if (!armed_q && vld_q[1]) begin
            if (synced) begin
                arm_cnt_d = '0;
            end else if (arm_cnt_q == CntLast) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            diff_q    <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            level_q   <= level_d;
            diff_q    <= diff_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            stb_q     <= stb_d;
        end
    end

endmodule

// File: rtl/meter_pulse_counter.sv
// Meter pulse counter: debounced pulses are prescaled into a saturating unit
// count, published to the billing machine through a snapshot handshake.
module meter_pulse_counter
    import ebm_pkg::*;
#(
    parameter int unsigned PULSES_PER_UNIT = PULSES_PER_UNIT_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pulse_in,
    input  logic                  clear_req,
    meter_pulse_counter_if.master snap_if,
    output logic                  overflow
);

    localparam int unsigned     PrescW    = 8;
    localparam logic [PrescW-1:0]  PrescLast = PrescW'(PULSES_PER_UNIT - 1);
    localparam logic [UNITS_W-1:0] UnitsSat  = UNITS_W'(UNITS_MAX);

    logic               pulse_stb;
    logic [PrescW-1:0]  presc_q, presc_d;
    logic [UNITS_W-1:0] units_q, units_d;
    logic               ovf_q, ovf_d;

    pub_state_e         state_q;
    logic [UNITS_W-1:0] today_q;
    logic               valid_q;

    pulse_debouncer #(
        .DebounceCycles (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (pulse_in),
        .pulse_stb_o (pulse_stb)
    );

    // Prescaler and saturating unit count; clear takes priority over a pulse.
    always_comb begin
        presc_d = presc_q;
        units_d = units_q;
        ovf_d   = ovf_q;
        if (clear_req) begin
            presc_d = '0;
            units_d = '0;
            ovf_d   = 1'b0;
        end else if (pulse_stb) begin
            if (presc_q == PrescLast) begin
                presc_d = '0;
                if (units_q == UnitsSat) begin
                    ovf_d = 1'b1;
                end else begin
                    units_d = units_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Running count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            units_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
            ovf_q   <= ovf_d;
        end
    end

    // Publish FSM with registered snapshot outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            today_q <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (snap_if.snap_req) begin
                        today_q <= units_q;
                        valid_q <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (snap_if.units_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign snap_if.units_today = today_q;
    assign snap_if.units_valid = valid_q;
    assign overflow            = ovf_q;

endmodule

// File: tb/tb_meter_pulse_counter.sv
// Scoreboard bench: expected snapshots are queued when snap_req is driven and
// checked when units_valid rises; a second instance covers saturation.
module tb_meter_pulse_counter;

    localparam int unsigned PPU = 10;

    logic clk;
    logic rst_n, rst2_n;
    logic pulse_in, clear_req, overflow;
    logic pulse2, clear2, overflow2;

    meter_pulse_counter_if bus ();
    meter_pulse_counter_if bus2 ();

    meter_pulse_counter #(
        .PULSES_PER_UNIT (PPU),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .clear_req (clear_req),
        .snap_if   (bus.master),
        .overflow  (overflow)
    );

    meter_pulse_counter #(
        .PULSES_PER_UNIT (2),
        .DEBOUNCE_CYCLES (2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst2_n),
        .pulse_in  (pulse2),
        .clear_req (clear2),
        .snap_if   (bus2.master),
        .overflow  (overflow2)
    );

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned m_units;
    int unsigned m_presc;
    logic [12:0] exp_q[$];
    logic [12:0] cur_exp;
    logic        vprev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_clear();
        m_units = 0;
        m_presc = 0;
    endtask

    task automatic m_pulse();
        if (m_presc == PPU - 1) begin
            m_presc = 0;
            if (m_units < 8191) m_units++;
        end else begin
            m_presc++;
        end
    endtask

    task automatic clean_pulse();
        pulse_in = 1'b1;
        idle(8);
        pulse_in = 1'b0;
        idle(8);
        m_pulse();
    endtask

    task automatic bouncy_pulse();
        for (int g = 0; g < 3; g++) begin
            pulse_in = 1'b1;
            idle(1);
            pulse_in = 1'b0;
            idle(1);
        end
        clean_pulse();
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        idle(1);
        clear_req = 1'b0;
        m_clear();
    endtask

    task automatic do_snap(input string tag);
        bus.snap_req = 1'b1;
        exp_q.push_back(13'(m_units));
        idle(1);
        bus.snap_req = 1'b0;
        check(tag, bus.units_valid, 1);
    endtask

    task automatic do_ready(input string tag);
        bus.units_ready = 1'b1;
        idle(1);
        bus.units_ready = 1'b0;
        check(tag, bus.units_valid, 0);
    endtask

    task automatic pulse_fast();
        pulse2 = 1'b1;
        idle(2);
        pulse2 = 1'b0;
        idle(2);
    endtask

    // Snapshot monitor: pop on valid rise, then require the value to hold.
    initial begin
        vprev = 1'b0;
        cur_exp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vprev = 1'b0;
            end else begin
                if (bus.units_valid && !vprev) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", exp_q.size(), 1);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("snap_val", bus.units_today, cur_exp);
                    end
                end else if (bus.units_valid) begin
                    check("snap_hold", bus.units_today, cur_exp);
                end
                vprev = bus.units_valid;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic main_seq();
        bit found;
        rst_n = 1'b0;
        pulse_in = 1'b0;
        clear_req = 1'b0;
        bus.snap_req = 1'b0;
        bus.units_ready = 1'b0;
        m_clear();
        idle(3);
        check("rst_valid", bus.units_valid, 0);
        check("rst_today", bus.units_today, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        idle(10);

        // Clean pulses: 25 -> 2 units, prescaler 5.
        for (int i = 0; i < 25; i++) clean_pulse();
        idle(12);
        check("clean_units", dut.units_q, m_units);
        check("clean_presc", dut.presc_q, m_presc);
        do_snap("clean_lat");
        idle(2);
        do_ready("clean_rdy");

        // Bouncy pulses: glitches must be rejected.
        do_clear();
        for (int i = 0; i < 10; i++) bouncy_pulse();
        idle(12);
        check("bounce_units", dut.units_q, m_units);
        check("bounce_presc", dut.presc_q, m_presc);
        do_snap("bounce_lat");
        do_ready("bounce_rdy");

        // Handshake: snapshot held while pulses arrive and snap_req is ignored.
        do_snap("hs_lat");
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.snap_req = 1'b1;
                idle(1);
                bus.snap_req = 1'b0;
            end
            clean_pulse();
        end
        idle(12);
        check("hs_run_cnt", dut.units_q, m_units);
        check("hs_still_valid", bus.units_valid, 1);
        bus.snap_req = 1'b1;
        do_ready("hs_rdy");
        bus.snap_req = 1'b0;
        idle(3);
        check("hs_snap_ign", bus.units_valid, 0);
        do_snap("hs_lat2");
        do_ready("hs_rdy2");

        // Clear coincident with the unit-completing pulse.
        do_clear();
        for (int i = 0; i < 9; i++) clean_pulse();
        idle(12);
        check("sim_presc9", dut.presc_q, m_presc);
        pulse_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dut.pulse_stb) found = 1'b1;
        end
        check("sim_stb_seen", found, 1);
        clear_req = 1'b1;
        idle(1);
        clear_req = 1'b0;
        m_clear();
        idle(7);
        pulse_in = 1'b0;
        idle(12);
        check("sim_units", dut.units_q, m_units);
        check("sim_presc", dut.presc_q, m_presc);

        // Reset during HOLD with the line high.
        for (int i = 0; i < 10; i++) clean_pulse();
        idle(12);
        do_snap("rst_lat");
        pulse_in = 1'b1;
        idle(3);
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", bus.units_valid, 0);
        check("rst_hold_today", bus.units_today, 0);
        m_clear();
        idle(2);
        rst_n = 1'b1;
        idle(30);
        check("rst_high_units", dut.units_q, 0);
        check("rst_high_presc", dut.presc_q, 0);
        pulse_in = 1'b0;
        idle(10);
        clean_pulse();
        idle(12);
        check("rst_new_presc", dut.presc_q, m_presc);
        do_snap("rst_lat2");
        do_ready("rst_rdy2");
    endtask

    task automatic sat_seq();
        rst2_n = 1'b0;
        pulse2 = 1'b0;
        clear2 = 1'b0;
        bus2.snap_req = 1'b0;
        bus2.units_ready = 1'b0;
        idle(3);
        rst2_n = 1'b1;
        idle(8);
        clear2 = 1'b1;
        idle(1);
        clear2 = 1'b0;
        for (int i = 0; i < 16380; i++) pulse_fast();
        idle(8);
        check("sat_preset", dut_sat.units_q, 8190);
        check("sat_preset_ovf", overflow2, 0);
        for (int i = 0; i < 2; i++) pulse_fast();
        idle(8);
        check("sat_max", dut_sat.units_q, 8191);
        check("sat_max_ovf", overflow2, 0);
        for (int i = 0; i < 18; i++) pulse_fast();
        idle(8);
        check("sat_hold", dut_sat.units_q, 8191);
        check("sat_ovf", overflow2, 1);
        bus2.snap_req = 1'b1;
        idle(1);
        bus2.snap_req = 1'b0;
        check("sat_snap_valid", bus2.units_valid, 1);
        check("sat_snap_val", bus2.units_today, 8191);
        clear2 = 1'b1;
        idle(1);
        clear2 = 1'b0;
        check("sat_clr_units", dut_sat.units_q, 0);
        check("sat_clr_ovf", overflow2, 0);
        check("sat_clr_presc", dut_sat.presc_q, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        fork
            main_seq();
            sat_seq();
        join
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
